float_adder_result_buffer: RTL and testbench

- Pipeline controller and result sink for the 3-stage float adder (align / cal / norm; register banks after align and after cal).
- Carries a valid bit and a tag alongside the adder's two register stages.
- Drives the adder's shared enable `e` and captures each normalised sum into a small FIFO with a valid/ready output.
- Sits directly downstream of the adder; the issue logic upstream sees one valid/ready operand port.

---
 rtl/float_adder_result_buffer.sv | 130 +++++++++++++
 tb/tb_float_adder_result_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_result_buffer.sv
// float_adder_result_buffer: pipeline controller and result FIFO for the
// 3-stage float adder (align / cal / norm).
//
// Ports:
//   clk, clrn         clock, async active-low reset
//   in_valid/in_tag   operand offer and its tag; in_ready accepts it
//   flush             sync discard of in-flight ops and buffered results
//   add_e             adder register enable (low = whole adder frozen)
//   add_s             adder norm-stage result
//   res_valid/ready   result handshake; res_data/res_tag/res_flags = head
//
// Optional: define FLOAT_ADDER_RESULT_FLAGS_EN to store per-entry
// {invalid, overflow, zero} flags; otherwise res_flags is 3'b000.
module float_adder_result_buffer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  input  logic             flush,
  output logic             add_e,
  input  logic [31:0]      add_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [2:0]       res_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             r_v1;
  logic             r_v2;
  logic [TAG_W-1:0] r_tag1;
  logic [TAG_W-1:0] r_tag2;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic [31:0]      r_data [DEPTH];
  logic [TAG_W-1:0] r_tagm [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_wr;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = ~w_empty & res_ready;

  // Freeze the adder only when a finished result has nowhere to go.
  assign add_e    = ~(r_v2 & w_full & ~w_pop);
  assign w_push   = r_v2 & add_e;
  assign w_wr     = w_push & ~flush;
  assign in_ready = add_e & ~flush;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (add_e) begin
        r_v1   <= in_valid;
        r_tag1 <= in_tag;
        r_v2   <= r_v1;
        r_tag2 <= r_tag1;
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wp] <= add_s;
      r_tagm[r_wp] <= r_tag2;
    end
  end

  // Head is masked to zero when empty so the outputs are clean after reset.
  assign res_valid = ~w_empty;
  assign res_data  = w_empty ? '0 : r_data[r_rp];
  assign res_tag   = w_empty ? '0 : r_tagm[r_rp];

`ifdef FLOAT_ADDER_RESULT_FLAGS_EN
  logic [2:0] r_flg [DEPTH];
  logic [7:0] w_exp;
  logic       w_frac_nz;
  logic       w_maxf;
  logic [2:0] w_flg;

  assign w_exp     = add_s[30:23];
  assign w_frac_nz = |add_s[22:0];
  assign w_maxf    = (add_s[30:0] == 31'h7f7fffff);
  assign w_flg[2]  = (w_exp == 8'hff) & w_frac_nz;
  assign w_flg[1]  = ((w_exp == 8'hff) & ~w_frac_nz) | w_maxf;
  assign w_flg[0]  = (add_s[30:0] == 31'h0);

  always_ff @(posedge clk) begin
    if (w_wr) r_flg[r_wp] <= w_flg;
  end

  assign res_flags = w_empty ? 3'b000 : r_flg[r_rp];
`else
  assign res_flags = 3'b000;
`endif

endmodule

// File: tb/tb_float_adder_result_buffer.sv
// tb_float_adder_result_buffer: directed + random bench with an
// opaque 2-register adder stand-in and an in-order result scoreboard.
module tb_float_adder_result_buffer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             clrn;
  logic             in_valid;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             flush;
  logic             add_e;
  logic [31:0]      add_s;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       res_flags;

  logic [31:0] cur_res;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]      q_d [$];
  logic [TAG_W-1:0] q_t [$];

  float_adder_result_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .flush     (flush),
    .add_e     (add_e),
    .add_s     (add_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_flags (res_flags)
  );

  always #5 clk = ~clk;

  // Adder stand-in: the sum offered with the operands travels through
  // the two enable-gated register banks and appears on add_s.
  logic [31:0] a_r1 = '0;
  logic [31:0] a_r2 = '0;
  always @(posedge clk) begin
    if (add_e) begin
      a_r1 <= cur_res;
      a_r2 <= a_r1;
    end
  end
  assign add_s = a_r2;

  function automatic logic [2:0] ref_flags(input logic [31:0] x);
    logic [2:0] f;
    f = 3'b000;
`ifdef FLOAT_ADDER_RESULT_FLAGS_EN
    if (x[30:23] == 8'hff && x[22:0] != 0) f[2] = 1'b1;
    if (x[30:23] == 8'hff && x[22:0] == 0) f[1] = 1'b1;
    if (x[30:0] == 31'h7f7fffff) f[1] = 1'b1;
    if (x[30:0] == 0) f[0] = 1'b1;
`else
    if (x === 32'hx) f = 3'b000;
`endif
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: mid-cycle, inputs and outputs are settled for the
  // coming edge. Accepted ops queue up; each pop must match the front.
  always @(negedge clk) begin
    if (!clrn || flush) begin
      q_d.delete();
      q_t.delete();
    end else begin
      if (res_valid && res_ready) begin
        chk("sb_nonempty", 32'(q_d.size() != 0), 32'd1);
        if (q_d.size() != 0) begin
          chk("sb_data", res_data, q_d[0]);
          chk("sb_tag", 32'(res_tag), 32'(q_t[0]));
          chk("sb_flags", 32'(res_flags), 32'(ref_flags(q_d[0])));
          void'(q_d.pop_front());
          void'(q_t.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_d.push_back(cur_res);
        q_t.push_back(in_tag);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b [8];
  logic        acc;
  logic [31:0] sp [5];

  initial begin
    clrn      = 1'b1;
    in_valid  = 1'b0;
    in_tag    = '0;
    flush     = 1'b0;
    res_ready = 1'b0;
    cur_res   = '0;
    #2 clrn = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_res_flags", 32'(res_flags), 32'd0);
    chk("rst_add_e", 32'(add_e), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 clrn = 1'b1;
    cyc();

    // Single op: 1.0 + 2.0 = 3.0, tag 3
    in_valid = 1'b1;
    in_tag   = 4'd3;
    cur_res  = 32'h40400000;
    chk("single_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("single_e0_valid", 32'(res_valid), 32'd0);
    cyc();
    chk("single_e1_valid", 32'(res_valid), 32'd0);
    cyc();
    chk("single_e2_valid", 32'(res_valid), 32'd1);
    chk("single_data", res_data, 32'h40400000);
    chk("single_tag", 32'(res_tag), 32'd3);
    chk("single_flags", 32'(res_flags), 32'd0);
    res_ready = 1'b1;
    cyc();
    chk("single_popped", 32'(res_valid), 32'd0);

    // Back-to-back: 8 ops, one result per cycle, adder never stalls
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_tag   = TAG_W'(c);
        cur_res  = $urandom;
        b2b[c]   = cur_res;
      end else begin
        in_valid = 1'b0;
      end
      chk("b2b_add_e", 32'(add_e), 32'd1);
      if (c >= 3) begin
        chk("b2b_valid", 32'(res_valid), 32'd1);
        chk("b2b_tag", 32'(res_tag), 32'(c - 3));
        chk("b2b_data", res_data, b2b[c-3]);
      end
      cyc();
    end
    chk("b2b_done", 32'(res_valid), 32'd0);

    // Backpressure: 6 ops into a 4-deep FIFO with no consumer
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(i);
      cur_res  = $urandom;
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_stall_e", 32'(add_e), 32'd0);
    chk("bp_stall_rdy", 32'(in_ready), 32'd0);
    chk("bp_head_tag0", 32'(res_tag), 32'd0);
    cyc();
    cyc();
    chk("bp_still_stall", 32'(add_e), 32'd0);
    res_ready = 1'b1;
    #1;
    chk("bp_pop_e", 32'(add_e), 32'd1);
    cyc();
    res_ready = 1'b0;
    #1;
    chk("bp_full_again", 32'(add_e), 32'd0);
    chk("bp_head_tag1", 32'(res_tag), 32'd1);
    res_ready = 1'b1;
    for (int k = 0; k < 20 && res_valid; k++) cyc();
    chk("bp_drained", 32'(res_valid), 32'd0);
    chk("bp_sb_empty", 32'(q_d.size()), 32'd0);

    // NaN: +inf + -inf
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 4'd5;
    cur_res   = 32'hFFC00000;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("nan_valid", 32'(res_valid), 32'd1);
    chk("nan_data", res_data, 32'hFFC00000);
    chk("nan_tag", 32'(res_tag), 32'd5);
`ifdef FLOAT_ADDER_RESULT_FLAGS_EN
    chk("nan_flags", 32'(res_flags), 32'b100);
`else
    chk("nan_flags", 32'(res_flags), 32'b000);
`endif
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;

    // Reset with 2 buffered and 2 in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(8 + i);
      cur_res  = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    chk("rstm_pre_valid", 32'(res_valid), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("rstm_valid", 32'(res_valid), 32'd0);
    chk("rstm_data", res_data, 32'd0);
    chk("rstm_tag", 32'(res_tag), 32'd0);
    chk("rstm_add_e", 32'(add_e), 32'd1);
    @(posedge clk);
    #2 clrn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rstm_no_stale", 32'(res_valid), 32'd0);
    end

    // Flush with 2 buffered and 2 in flight, op offered in flush cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(12 + i);
      cur_res  = $urandom;
      cyc();
    end
    chk("fl_pre_valid", 32'(res_valid), 32'd1);
    flush   = 1'b1;
    in_tag  = 4'd7;
    cur_res = $urandom;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    chk("fl_cleared", 32'(res_valid), 32'd0);
    in_valid = 1'b1;
    in_tag   = 4'd9;
    cur_res  = 32'h3f800000;
    cyc();
    in_valid = 1'b0;
    chk("fl_k0", 32'(res_valid), 32'd0);
    cyc();
    chk("fl_k1", 32'(res_valid), 32'd0);
    cyc();
    chk("fl_k2_valid", 32'(res_valid), 32'd1);
    chk("fl_k2_tag", 32'(res_tag), 32'd9);
    chk("fl_k2_data", res_data, 32'h3f800000);
    res_ready = 1'b1;
    cyc();
    chk("fl_alone", 32'(res_valid), 32'd0);

    // Random traffic; upstream holds its offer until accepted
    sp[0] = 32'h7f800000;
    sp[1] = 32'hff7fffff;
    sp[2] = 32'h00000000;
    sp[3] = 32'h80000000;
    sp[4] = 32'h7fc00001;
    acc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_tag   = TAG_W'($urandom);
        if ($urandom_range(0, 4) == 0) cur_res = sp[$urandom_range(0, 4)];
        else cur_res = $urandom;
      end
      res_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      #3 acc = in_valid && in_ready;
      cyc();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 40 && (res_valid || q_d.size() != 0); k++) cyc();
    chk("rnd_drained", 32'(res_valid), 32'd0);
    chk("rnd_sb_empty", 32'(q_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
